// File: rtl/lsu_mem_master.sv
// Purpose : load/store initiator for a word-wide memory without byte enables (RMW for SB/SH).
// Latency : accept->resp_valid: load 2, SW 2, SB/SH 3, error 1 cycles.
// Backpr. : one request at a time, req_ready high only in IDLE; no response backpressure.
//
// Ports:
//   i_clk, i_rst                 clock (rising edge), async active-high reset
//   req_valid/req_ready          request handshake; req_we, req_funct3, req_addr, req_wdata
//   resp_valid/resp_rdata/resp_err  single-cycle completion pulse with extended load data
//   mem_read_en/mem_write_en/mem_addr/mem_wdata/mem_rdata  word memory port (mem_addr = word index)
module lsu_mem_master #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_read_en,
  output logic            mem_write_en,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [XLEN-1:0] DEPTH_W = XLEN'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [15:0]       wdata_q, wdata_d;  // only the low half is ever merged by SB/SH
  logic              req_ready_d, resp_valid_d, resp_err_d;
  logic              mem_read_en_d, mem_write_en_d;
  logic [XLEN-1:0]   resp_rdata_d, mem_addr_d, mem_wdata_d;
  logic              accept;

  // Illegal funct3, misalignment, or word index outside the memory.
  function automatic logic req_bad(input logic we, input logic [2:0] f3,
                                   input logic [XLEN-1:0] a);
    logic bad;
    bad = 1'b0;
    if (we) bad = (f3 > 3'b010);
    else    bad = (f3 == 3'b011) || (f3[2:1] == 2'b11);
    if (f3[1:0] == 2'b01 && a[0])          bad = 1'b1;
    if (f3[1:0] == 2'b10 && a[1:0] != 2'b00) bad = 1'b1;
    if ({2'b00, a[XLEN-1:2]} >= DEPTH_W)   bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] w,
                                                   input logic [2:0] f3,
                                                   input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [XLEN-1:0] r;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  r = {{(XLEN-8){b[7]}}, b};
      3'b100:  r = {{(XLEN-8){1'b0}}, b};
      3'b001:  r = {{(XLEN-16){h[15]}}, h};
      3'b101:  r = {{(XLEN-16){1'b0}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace the addressed byte/half of the word just read.
  function automatic logic [XLEN-1:0] store_merge(input logic [XLEN-1:0] w,
                                                  input logic [2:0] f3,
                                                  input logic [1:0] off,
                                                  input logic [15:0] d);
    logic [XLEN-1:0] r;
    r = w;
    if (f3[1:0] == 2'b00) r[{off, 3'b000} +: 8]     = d[7:0];
    else                  r[{off[1], 4'b0000} +: 16] = d;
    return r;
  endfunction

  assign accept = req_valid && req_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      off_q        <= 2'b00;
      wdata_q      <= '0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      req_ready    <= req_ready_d;
      resp_valid   <= resp_valid_d;
      resp_rdata   <= resp_rdata_d;
      resp_err     <= resp_err_d;
      mem_read_en  <= mem_read_en_d;
      mem_write_en <= mem_write_en_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
    end
  end

  // Next-state and next-output logic; outputs are registered so each state's
  // outputs are computed on the transition into it.
  always_comb begin
    state_d        = state_q;
    we_d           = we_q;
    f3_d           = f3_q;
    off_d          = off_q;
    wdata_d        = wdata_q;
    req_ready_d    = req_ready;
    resp_valid_d   = 1'b0;
    resp_rdata_d   = '0;
    resp_err_d     = 1'b0;
    mem_read_en_d  = 1'b0;
    mem_write_en_d = 1'b0;
    mem_addr_d     = mem_addr;
    mem_wdata_d    = mem_wdata;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d        = req_we;
          f3_d        = req_funct3;
          off_d       = req_addr[1:0];
          wdata_d     = req_wdata[15:0];
          req_ready_d = 1'b0;
          if (req_bad(req_we, req_funct3, req_addr)) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            mem_addr_d = XLEN'(req_addr[AW+1:2]);
            if (req_we && req_funct3 == 3'b010) begin
              state_d        = S_WR;
              mem_write_en_d = 1'b1;
              mem_wdata_d    = req_wdata;
            end else begin
              state_d       = S_RD;
              mem_read_en_d = 1'b1;
            end
          end
        end
      end
      S_RD: begin
        if (we_q) begin
          state_d        = S_WR;
          mem_write_en_d = 1'b1;
          mem_wdata_d    = store_merge(mem_rdata, f3_q, off_q, wdata_q);
        end else begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_extract(mem_rdata, f3_q, off_q);
        end
      end
      S_WR: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

endmodule
